// File: rtl/mmio_rd_req_scheduler.sv
// MMIO read-request scheduler: buffers decoded read requests, issues them under an
// outstanding-read allowance, and watches the oldest outstanding read for a timeout.
module mmio_rd_req_scheduler #(
  parameter int FIFO_DEPTH       = 4,
  parameter int READ_ALLOWANCE   = 1,
  parameter int TAG_WIDTH        = 10,
  parameter int LOWER_ADDR_WIDTH = 7,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_rd_valid,
  output logic                        in_rd_ready,
  input  logic [TAG_WIDTH-1:0]        in_rd_tag,
  input  logic [1:0]                  in_rd_length,
  input  logic [15:0]                 in_rd_req_id,
  input  logic [LOWER_ADDR_WIDTH-1:0] in_rd_lower_addr,
  input  logic [2:0]                  in_rd_attr,
  input  logic [2:0]                  in_rd_tc,
  output logic                        o_tlp_rd,
  output logic [TAG_WIDTH-1:0]        o_tlp_rd_tag,
  output logic [1:0]                  o_tlp_rd_length,
  output logic [15:0]                 o_tlp_rd_req_id,
  output logic [LOWER_ADDR_WIDTH-1:0] o_tlp_rd_lower_addr,
  output logic [2:0]                  o_tlp_attr,
  output logic [2:0]                  o_tlp_tc,
  input  logic                        i_cpl_done,
  output logic                        o_fake_rsp_req,
  output logic [3:0]                  o_outstanding,
  output logic                        o_cpl_err
);

  // state     | meaning
  // T_IDLE    | nothing outstanding, timer cleared
  // T_COUNT   | timing the oldest outstanding read
  // T_EXPIRED | fake completion requested, waiting for the bridge's completion
  localparam logic [1:0] T_IDLE    = 2'd0;
  localparam logic [1:0] T_COUNT   = 2'd1;
  localparam logic [1:0] T_EXPIRED = 2'd2;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int DW = TAG_WIDTH + 2 + 16 + LOWER_ADDR_WIDTH + 3 + 3;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          rd_q;
  logic [3:0]    out_q, out_d;
  logic          err_q, err_d;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          fake_q, fake_d;
  logic          push, pop, dec;

  assign in_rd_ready = count_q < CW'(FIFO_DEPTH);
  assign push        = in_rd_valid && in_rd_ready;
  assign pop         = (count_q != '0) && (out_q < 4'(READ_ALLOWANCE));
  // A completion with nothing outstanding is an error and must not underflow the count.
  assign dec         = i_cpl_done && (out_q != 4'd0);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_rd_tag, in_rd_length, in_rd_req_id,
                                  in_rd_lower_addr, in_rd_attr, in_rd_tc};
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    dout_d   = pop ? mem_q[rd_ptr_q] : dout_q;
    out_d    = out_q + 4'(pop) - 4'(dec);
    err_d    = err_q | (i_cpl_done && (out_q == 4'd0));
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fake_d  = 1'b0;
    case (state_q)
      T_IDLE: begin
        timer_d = '0;
        if (out_d != 4'd0) state_d = T_COUNT;
      end
      T_COUNT: begin
        if (i_cpl_done) begin
          timer_d = '0;
          state_d = (out_d != 4'd0) ? T_COUNT : T_IDLE;
        end else if (timer_q == TMAX) begin
          fake_d  = 1'b1;
          state_d = T_EXPIRED;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      T_EXPIRED: begin
        if (i_cpl_done) begin
          timer_d = '0;
          state_d = (out_d != 4'd0) ? T_COUNT : T_IDLE;
        end
      end
      default: begin
        state_d = T_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      rd_q     <= 1'b0;
      out_q    <= 4'd0;
      err_q    <= 1'b0;
      state_q  <= T_IDLE;
      timer_q  <= '0;
      fake_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      rd_q     <= pop;
      out_q    <= out_d;
      err_q    <= err_d;
      state_q  <= state_d;
      timer_q  <= timer_d;
      fake_q   <= fake_d;
    end
  end

  assign {o_tlp_rd_tag, o_tlp_rd_length, o_tlp_rd_req_id,
          o_tlp_rd_lower_addr, o_tlp_attr, o_tlp_tc} = dout_q;
  assign o_tlp_rd       = rd_q;
  assign o_outstanding  = out_q;
  assign o_cpl_err      = err_q;
  assign o_fake_rsp_req = fake_q;

endmodule

// File: tb/tb_mmio_rd_req_scheduler.sv
// Directed bench for mmio_rd_req_scheduler: a per-cycle vector table for issue/order,
// then hand-written sequences for FIFO full, watchdog, simultaneous events and reset.
module tb_mmio_rd_req_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_rd_valid, i_cpl_done;
  logic [9:0] in_rd_tag;
  logic [1:0] in_rd_length;
  logic [15:0] in_rd_req_id;
  logic [6:0] in_rd_lower_addr;
  logic [2:0] in_rd_attr, in_rd_tc;

  logic       in_rd_ready, o_tlp_rd, o_fake_rsp_req, o_cpl_err;
  logic [9:0] o_tlp_rd_tag;
  logic [1:0] o_tlp_rd_length;
  logic [15:0] o_tlp_rd_req_id;
  logic [6:0] o_tlp_rd_lower_addr;
  logic [2:0] o_tlp_attr, o_tlp_tc;
  logic [3:0] o_outstanding;

  logic       b_ready, b_rd, b_fake, b_err;
  logic [9:0] b_tag;
  logic [1:0] b_len;
  logic [15:0] b_rid;
  logic [6:0] b_la;
  logic [2:0] b_attr, b_tc;
  logic [3:0] b_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mmio_rd_req_scheduler #(.TIMEOUT_CYCLES(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_rd_valid(in_rd_valid), .in_rd_ready(in_rd_ready), .in_rd_tag(in_rd_tag),
    .in_rd_length(in_rd_length), .in_rd_req_id(in_rd_req_id),
    .in_rd_lower_addr(in_rd_lower_addr), .in_rd_attr(in_rd_attr), .in_rd_tc(in_rd_tc),
    .o_tlp_rd(o_tlp_rd), .o_tlp_rd_tag(o_tlp_rd_tag), .o_tlp_rd_length(o_tlp_rd_length),
    .o_tlp_rd_req_id(o_tlp_rd_req_id), .o_tlp_rd_lower_addr(o_tlp_rd_lower_addr),
    .o_tlp_attr(o_tlp_attr), .o_tlp_tc(o_tlp_tc), .i_cpl_done(i_cpl_done),
    .o_fake_rsp_req(o_fake_rsp_req), .o_outstanding(o_outstanding), .o_cpl_err(o_cpl_err)
  );

  // Second instance with an allowance of two, for the issue-plus-completion case.
  mmio_rd_req_scheduler #(.READ_ALLOWANCE(2), .TIMEOUT_CYCLES(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_rd_valid(in_rd_valid), .in_rd_ready(b_ready), .in_rd_tag(in_rd_tag),
    .in_rd_length(in_rd_length), .in_rd_req_id(in_rd_req_id),
    .in_rd_lower_addr(in_rd_lower_addr), .in_rd_attr(in_rd_attr), .in_rd_tc(in_rd_tc),
    .o_tlp_rd(b_rd), .o_tlp_rd_tag(b_tag), .o_tlp_rd_length(b_len),
    .o_tlp_rd_req_id(b_rid), .o_tlp_rd_lower_addr(b_la),
    .o_tlp_attr(b_attr), .o_tlp_tc(b_tc), .i_cpl_done(i_cpl_done),
    .o_fake_rsp_req(b_fake), .o_outstanding(b_out), .o_cpl_err(b_err)
  );

  typedef struct {
    logic       v;
    logic [9:0] tag;
    logic       cpl;
    logic       e_rdy;
    logic       e_rd;
    logic [9:0] e_tag;
    logic [3:0] e_out;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Field values are a fixed function of the tag, so the expected fields follow from the tag.
  function automatic logic [30:0] fields_of(input logic [9:0] t);
    if (t == 10'h005) return {2'd2, 16'h0100, 7'h08, 3'd1, 3'd2};
    return {2'd1, 16'h0200 + 16'(t), 7'h10 + 7'(t), 3'd0, 3'd3};
  endfunction

  task automatic drive(input logic v, input logic [9:0] t, input logic c);
    in_rd_valid = v;
    in_rd_tag   = t;
    {in_rd_length, in_rd_req_id, in_rd_lower_addr, in_rd_attr, in_rd_tc} = fields_of(t);
    i_cpl_done  = c;
  endtask

  task automatic do_reset();
    drive(1'b0, 10'h0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_rd(input logic [9:0] exp_tag);
    for (int i = 0; i < 8; i++) begin
      if (o_tlp_rd) begin
        chk("order_tag", 32'(o_tlp_rd_tag), 32'(exp_tag));
        chk("order_fields", 32'({o_tlp_rd_length, o_tlp_rd_req_id, o_tlp_rd_lower_addr,
                                 o_tlp_attr, o_tlp_tc}), 32'(fields_of(exp_tag)));
        return;
      end
      @(negedge clk);
    end
    n_cmp++;
    n_err++;
    $display("FAIL wait_rd: no strobe for tag 0x%0h within 8 cycles", exp_tag);
  endtask

  function automatic vec_t mkv(input logic v, input logic [9:0] t, input logic c,
                               input logic rdy, input logic rd, input logic [9:0] et,
                               input logic [3:0] eo);
    vec_t r;
    r.v = v; r.tag = t; r.cpl = c;
    r.e_rdy = rdy; r.e_rd = rd; r.e_tag = et; r.e_out = eo;
    return r;
  endfunction

  initial begin
    vec_t vecs[14];
    int   first, pulses, cnt;

    // Each row: outputs expected at this negedge, then inputs applied for the next edge.
    vecs[0]  = mkv(1, 10'h5, 0, 1, 0, 10'h0, 0);
    vecs[1]  = mkv(0, 10'h0, 0, 1, 0, 10'h0, 0);
    vecs[2]  = mkv(0, 10'h0, 0, 1, 1, 10'h5, 1);
    vecs[3]  = mkv(0, 10'h0, 1, 1, 0, 10'h5, 1);
    vecs[4]  = mkv(1, 10'h1, 0, 1, 0, 10'h5, 0);
    vecs[5]  = mkv(1, 10'h2, 0, 1, 0, 10'h5, 0);
    vecs[6]  = mkv(1, 10'h3, 0, 1, 1, 10'h1, 1);
    vecs[7]  = mkv(0, 10'h0, 0, 1, 0, 10'h1, 1);
    vecs[8]  = mkv(0, 10'h0, 1, 1, 0, 10'h1, 1);
    vecs[9]  = mkv(0, 10'h0, 0, 1, 0, 10'h1, 0);
    vecs[10] = mkv(0, 10'h0, 1, 1, 1, 10'h2, 1);
    vecs[11] = mkv(0, 10'h0, 0, 1, 0, 10'h2, 0);
    vecs[12] = mkv(0, 10'h0, 1, 1, 1, 10'h3, 1);
    vecs[13] = mkv(0, 10'h0, 0, 1, 0, 10'h3, 0);

    do_reset();
    chk("rst_fields", 32'({o_tlp_rd_length, o_tlp_rd_req_id, o_tlp_rd_lower_addr,
                           o_tlp_attr, o_tlp_tc}), 32'h0);
    chk("rst_err", 32'(o_cpl_err), 32'h0);

    // Single read, then allowance throttling with strict ordering.
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("v%0d_ready", i), 32'(in_rd_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_rd", i), 32'(o_tlp_rd), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_tag", i), 32'(o_tlp_rd_tag), 32'(vecs[i].e_tag));
      chk($sformatf("v%0d_out", i), 32'(o_outstanding), 32'(vecs[i].e_out));
      chk($sformatf("v%0d_fake", i), 32'(o_fake_rsp_req), 32'h0);
      if (vecs[i].e_rd)
        chk($sformatf("v%0d_fields", i), 32'({o_tlp_rd_length, o_tlp_rd_req_id,
            o_tlp_rd_lower_addr, o_tlp_attr, o_tlp_tc}), 32'(fields_of(vecs[i].e_tag)));
      drive(vecs[i].v, vecs[i].tag, vecs[i].cpl);
      @(negedge clk);
    end

    // FIFO full: five accepted (one issued, four queued), sixth held until a slot frees.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      chk("full_rdy", 32'(in_rd_ready), 32'h1);
      drive(1'b1, 10'h10 + 10'(k), 1'b0);
      @(negedge clk);
    end
    chk("full_rdy_drop", 32'(in_rd_ready), 32'h0);
    chk("full_out", 32'(o_outstanding), 32'h1);
    chk("full_first_tag", 32'(o_tlp_rd_tag), 32'h10);
    drive(1'b1, 10'h15, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("full_hold", 32'(in_rd_ready), 32'h0);
    end
    drive(1'b1, 10'h15, 1'b1);
    @(negedge clk);
    drive(1'b1, 10'h15, 1'b0);
    chk("full_after_cpl_rdy", 32'(in_rd_ready), 32'h0);
    chk("full_after_cpl_out", 32'(o_outstanding), 32'h0);
    @(negedge clk);
    chk("full_reissue_rd", 32'(o_tlp_rd), 32'h1);
    chk("full_reissue_tag", 32'(o_tlp_rd_tag), 32'h11);
    chk("full_slot_free", 32'(in_rd_ready), 32'h1);
    @(negedge clk);
    drive(1'b0, 10'h0, 1'b0);
    chk("full_refilled", 32'(in_rd_ready), 32'h0);
    for (int t = 12; t < 16; t++) begin
      drive(1'b0, 10'h0, 1'b1);
      @(negedge clk);
      drive(1'b0, 10'h0, 1'b0);
      wait_rd(10'h10 + 10'(t - 10));
    end
    drive(1'b0, 10'h0, 1'b1);
    @(negedge clk);
    drive(1'b0, 10'h0, 1'b0);
    @(negedge clk);
    chk("full_drained_out", 32'(o_outstanding), 32'h0);

    // Watchdog: one pulse exactly 16 cycles after the count became nonzero.
    do_reset();
    drive(1'b1, 10'h40, 1'b0);
    @(negedge clk);
    drive(1'b0, 10'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (o_outstanding == 4'd1) break;
      @(negedge clk);
    end
    chk("wd_out_up", 32'(o_outstanding), 32'h1);
    first = -1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_fake_rsp_req) begin
        pulses++;
        if (first < 0) first = i;
      end
      @(negedge clk);
    end
    chk("wd_pulses", 32'(pulses), 32'h1);
    chk("wd_delay", 32'(first), 32'd16);
    chk("wd_out_held", 32'(o_outstanding), 32'h1);
    drive(1'b0, 10'h0, 1'b1);
    @(negedge clk);
    drive(1'b0, 10'h0, 1'b0);
    chk("wd_out_clear", 32'(o_outstanding), 32'h0);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_fake_rsp_req) pulses++;
    end
    chk("wd_idle_quiet", 32'(pulses), 32'h0);

    // Issue and completion in the same cycle with allowance two.
    do_reset();
    drive(1'b1, 10'd21, 1'b0);
    @(negedge clk);
    drive(1'b1, 10'd22, 1'b0);
    @(negedge clk);
    chk("sim_pre_out", 32'(b_out), 32'h1);
    drive(1'b0, 10'h0, 1'b1);
    @(negedge clk);
    chk("sim_out_same", 32'(b_out), 32'h1);
    chk("sim_rd", 32'(b_rd), 32'h1);
    chk("sim_tag", 32'(b_tag), 32'd22);
    drive(1'b0, 10'h0, 1'b1);
    @(negedge clk);
    drive(1'b0, 10'h0, 1'b0);
    chk("sim_out_zero", 32'(b_out), 32'h0);

    // Completion with nothing outstanding: sticky error, count stays at zero.
    do_reset();
    chk("err_pre", 32'({o_cpl_err, b_err}), 32'h0);
    drive(1'b0, 10'h0, 1'b1);
    @(negedge clk);
    drive(1'b0, 10'h0, 1'b0);
    chk("err_set", 32'({o_cpl_err, b_err}), 32'h3);
    chk("err_out", 32'({o_outstanding, b_out}), 32'h0);
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'({o_cpl_err, b_err}), 32'h3);

    // Async reset with three queued and one outstanding, error flag still set.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 10'd30 + 10'(k), 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 10'h0, 1'b0);
    chk("rst6_pre_out", 32'(o_outstanding), 32'h1);
    chk("rst6_pre_tag", 32'(o_tlp_rd_tag), 32'd30);
    #2 rst_n = 1'b0;
    #1;
    chk("rst6_tag", 32'(o_tlp_rd_tag), 32'h0);
    chk("rst6_out", 32'(o_outstanding), 32'h0);
    chk("rst6_err", 32'(o_cpl_err), 32'h0);
    chk("rst6_rd_fake", 32'({o_tlp_rd, o_fake_rsp_req}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_tlp_rd || !in_rd_ready) cnt++;
    end
    chk("rst6_no_strobe", 32'(cnt), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
